// File: rtl/bram_dump_reader_pkg.sv
// ============================================================================
// Module      : bram_dump_reader_pkg
// Description : Shared constants and FSM state encoding for the bram32 dump
//               reader. Macro BRAM_DUMP_CHECKSUM_EN adds the CSUM state.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package bram_dump_reader_pkg;

    localparam int unsigned c_bytes_per_word = 4;
    localparam logic [1:0]  c_last_byte_idx  = 2'(c_bytes_per_word - 1);

    typedef enum logic [2:0] {
        DUMP_IDLE = 3'd0,
        DUMP_ADDR = 3'd1,
        DUMP_WAIT = 3'd2,
        DUMP_LOAD = 3'd3,
        DUMP_SEND = 3'd4,
        DUMP_DONE = 3'd5
`ifdef BRAM_DUMP_CHECKSUM_EN
        ,
        DUMP_CSUM = 3'd6
`endif
    } dump_state_t;

endpackage

`default_nettype wire

// File: rtl/bram_dump_reader_if.sv
// ============================================================================
// Module      : bram_dump_reader_if
// Description : Control, bram32 debug-port and byte-stream signals of the dump
//               reader. master = the reader, slave = its environment.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface bram_dump_reader_if #(
    parameter int ADDR_WIDTH = 12,
    parameter int DATA_WIDTH = 32,
    parameter int CNT_WIDTH  = 11
);
    logic                  start;
    logic [ADDR_WIDTH-1:0] base_addr;
    logic [CNT_WIDTH-1:0]  word_count;
    logic                  busy;
    logic                  done;
    logic [ADDR_WIDTH-1:0] debug_addr;
    logic [DATA_WIDTH-1:0] debug_data;
    logic [7:0]            tx_data;
    logic                  tx_valid;
    logic                  tx_ready;

    modport master (
        input  start, base_addr, word_count, debug_data, tx_ready,
        output busy, done, debug_addr, tx_data, tx_valid
    );

    modport slave (
        output start, base_addr, word_count, debug_data, tx_ready,
        input  busy, done, debug_addr, tx_data, tx_valid
    );
endinterface

`default_nettype wire

// File: rtl/bram_dump_reader_serializer.sv
// ============================================================================
// Module      : dump_byte_serializer
// Description : Little-endian word-to-byte serializer with valid/ready output.
//               Macro BRAM_DUMP_CHECKSUM_EN adds the running sum and CSUM byte.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module dump_byte_serializer
    import bram_dump_reader_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  wire logic                  clk,
    input  wire logic                  rst,
    input  wire logic                  i_load,
    input  wire logic [DATA_WIDTH-1:0] i_word,
`ifdef BRAM_DUMP_CHECKSUM_EN
    input  wire logic                  i_sum_clear,
    input  wire logic                  i_csum_load,
`endif
    input  wire logic                  i_tx_ready,
    output logic [7:0]                 o_tx_data,
    output logic                       o_tx_valid,
    output logic                       o_word_sent
);

    logic [DATA_WIDTH-1:0] r_shift;
    logic [1:0]            r_byte_idx;
    logic [7:0]            r_data;
    logic                  r_valid;
    logic                  w_xfer;
    logic [1:0]            w_next_idx;
    logic [4:0]            w_bit_base;

    assign w_xfer      = r_valid & i_tx_ready;
    assign w_next_idx  = r_byte_idx + 2'd1;
    assign w_bit_base  = {w_next_idx, 3'b000};
    assign o_word_sent = w_xfer & (r_byte_idx == c_last_byte_idx);
    assign o_tx_data   = r_data;
    assign o_tx_valid  = r_valid;

`ifdef BRAM_DUMP_CHECKSUM_EN
    logic [7:0] r_sum;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_sum <= 8'd0;
        end else if (i_sum_clear) begin
            r_sum <= 8'd0;
        end else if (w_xfer) begin
            r_sum <= r_sum + r_data;
        end
    end
`endif

    // tx_data is registered so it holds still during stalls without extra muxing
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_shift    <= '0;
            r_byte_idx <= 2'd0;
            r_data     <= 8'd0;
            r_valid    <= 1'b0;
        end else if (i_load) begin
            r_shift    <= i_word;
            r_byte_idx <= 2'd0;
            r_data     <= i_word[7:0];
            r_valid    <= 1'b1;
`ifdef BRAM_DUMP_CHECKSUM_EN
        end else if (i_csum_load) begin
            // Parked on the last index so its transfer raises word_sent
            r_byte_idx <= c_last_byte_idx;
            r_data     <= 8'd0 - r_sum;
            r_valid    <= 1'b1;
`endif
        end else if (w_xfer) begin
            if (r_byte_idx == c_last_byte_idx) begin
                r_valid <= 1'b0;
            end else begin
                r_byte_idx <= w_next_idx;
                r_data     <= r_shift[w_bit_base +: 8];
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/bram_dump_reader.sv
// ============================================================================
// Module      : bram_dump_reader
// Description : Walks a word range of a bram32 debug port and streams it out
//               as bytes. Macro BRAM_DUMP_CHECKSUM_EN appends a checksum byte.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module bram_dump_reader
    import bram_dump_reader_pkg::*;
#(
    parameter int ADDR_WIDTH = 12,
    parameter int DATA_WIDTH = 32,
    parameter int RD_LAT     = 1,
    parameter int CNT_WIDTH  = 11
) (
    input  wire logic           clk,
    input  wire logic           rst,
    bram_dump_reader_if.master  bus
);

    localparam int c_wait_w = (RD_LAT < 2) ? 1 : $clog2(RD_LAT + 1);

    dump_state_t           r_state;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [ADDR_WIDTH-1:0] r_debug_addr;
    logic [CNT_WIDTH-1:0]  r_rem;
    logic [c_wait_w-1:0]   r_wait;
    logic                  r_busy;
    logic                  r_done;
    logic                  w_load;
    logic                  w_word_sent;

    assign w_load         = (r_state == DUMP_LOAD);
    assign bus.busy       = r_busy;
    assign bus.done       = r_done;
    assign bus.debug_addr = r_debug_addr;

`ifdef BRAM_DUMP_CHECKSUM_EN
    logic r_csum_go;
    logic w_accept;

    assign w_accept = (r_state == DUMP_IDLE) & bus.start;
`endif

    dump_byte_serializer #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_serializer (
        .clk         (clk),
        .rst         (rst),
        .i_load      (w_load),
        .i_word      (bus.debug_data),
`ifdef BRAM_DUMP_CHECKSUM_EN
        .i_sum_clear (w_accept),
        .i_csum_load (r_csum_go),
`endif
        .i_tx_ready  (bus.tx_ready),
        .o_tx_data   (bus.tx_data),
        .o_tx_valid  (bus.tx_valid),
        .o_word_sent (w_word_sent)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state      <= DUMP_IDLE;
            r_addr       <= '0;
            r_debug_addr <= '0;
            r_rem        <= '0;
            r_wait       <= '0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
`ifdef BRAM_DUMP_CHECKSUM_EN
            r_csum_go    <= 1'b0;
`endif
        end else begin
            case (r_state)
                DUMP_IDLE: begin
                    if (bus.start) begin
                        r_addr <= {bus.base_addr[ADDR_WIDTH-1:2], 2'b00};
                        r_rem  <= bus.word_count;
                        if (bus.word_count == '0) begin
`ifdef BRAM_DUMP_CHECKSUM_EN
                            r_state   <= DUMP_CSUM;
                            r_busy    <= 1'b1;
                            r_csum_go <= 1'b1;
`else
                            r_state <= DUMP_DONE;
                            r_done  <= 1'b1;
`endif
                        end else begin
                            r_state <= DUMP_ADDR;
                            r_busy  <= 1'b1;
                        end
                    end
                end
                DUMP_ADDR: begin
                    r_debug_addr <= r_addr;
                    r_wait       <= c_wait_w'(RD_LAT);
                    r_state      <= (RD_LAT == 0) ? DUMP_LOAD : DUMP_WAIT;
                end
                DUMP_WAIT: begin
                    r_wait <= r_wait - c_wait_w'(1);
                    if (r_wait <= c_wait_w'(1)) begin
                        r_state <= DUMP_LOAD;
                    end
                end
                DUMP_LOAD: begin
                    r_state <= DUMP_SEND;
                end
                DUMP_SEND: begin
                    if (w_word_sent) begin
                        r_rem  <= r_rem - CNT_WIDTH'(1);
                        r_addr <= r_addr + ADDR_WIDTH'(c_bytes_per_word);
                        if (r_rem == CNT_WIDTH'(1)) begin
`ifdef BRAM_DUMP_CHECKSUM_EN
                            r_state   <= DUMP_CSUM;
                            r_csum_go <= 1'b1;
`else
                            r_state <= DUMP_DONE;
                            r_done  <= 1'b1;
                            r_busy  <= 1'b0;
`endif
                        end else begin
                            r_state <= DUMP_ADDR;
                        end
                    end
                end
`ifdef BRAM_DUMP_CHECKSUM_EN
                DUMP_CSUM: begin
                    r_csum_go <= 1'b0;
                    if (w_word_sent) begin
                        r_state <= DUMP_DONE;
                        r_done  <= 1'b1;
                        r_busy  <= 1'b0;
                    end
                end
`endif
                DUMP_DONE: begin
                    r_done  <= 1'b0;
                    r_state <= DUMP_IDLE;
                end
                default: begin
                    r_state <= DUMP_IDLE;
                end
            endcase
        end
    end

endmodule

`default_nettype wire
